// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: 3-bit FSM state encodings, line levels and frame defaults.
// The RX block is meant to import this same package.
package uart_tx_serializer_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start, DATA_BITS LSB-first, [parity], STOP_BITS, one bit per baud_done period.
// Define UART_TX_PARITY_EN to insert the parity bit (even, or odd when PARITY_ODD=1).
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int STOP_BITS  = DEF_STOP_BITS,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_done,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_serializer: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
  end

  logic [2:0]           state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           cnt;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      shift   <= '0;
      cnt     <= '0;
      tx      <= LINE_IDLE;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= LINE_IDLE;
          if (tx_start) begin
            shift   <= tx_data;
            state   <= ST_SYNC;
            tx_busy <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
          end
        end
        // Align the frame to the baud grid so the start bit lasts a full period.
        ST_SYNC: if (baud_done) begin
          state <= ST_START;
          tx    <= LINE_START;
        end
        ST_START: if (baud_done) begin
          state <= ST_DATA;
          tx    <= shift[0];
          cnt   <= '0;
        end
        ST_DATA: if (baud_done) begin
          if (cnt == LAST_DATA) begin
            cnt <= '0;
`ifdef UART_TX_PARITY_EN
            state <= ST_PARITY;
            tx    <= par;
`else
            state <= ST_STOP;
            tx    <= LINE_IDLE;
`endif
          end else begin
            shift <= shift >> 1;
            tx    <= shift[1];
            cnt   <= cnt + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: if (baud_done) begin
          state <= ST_STOP;
          tx    <= LINE_IDLE;
          cnt   <= '0;
        end
`endif
        ST_STOP: if (baud_done) begin
          if (cnt == LAST_STOP) begin
            state   <= ST_IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          tx      <= LINE_IDLE;
          tx_busy <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer; baud_done pulses every 4 clk.
// Build with UART_TX_PARITY_EN to exercise parity with STOP_BITS=2 (even and odd instances).
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int P  = 1;
  localparam int SB = 2;
`else
  localparam int P  = 0;
  localparam int SB = 1;
`endif
  localparam int DB = 8;
  localparam int L  = 1 + DB + P + SB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_done = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_busy, tx_done;

  int n_chk = 0;
  int n_fail = 0;

  logic txs [256];
  logic dns [256];
  logic bss [256];

  uart_tx_serializer #(.DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .baud_done(baud_done), .tx_start(tx_start),
    .tx_data(tx_data), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

`ifdef UART_TX_PARITY_EN
  logic tx_odd, busy_odd, done_odd;
  logic txo [256];
  uart_tx_serializer #(.DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .reset(reset), .baud_done(baud_done), .tx_start(tx_start),
    .tx_data(tx_data), .tx(tx_odd), .tx_busy(busy_odd), .tx_done(done_odd)
  );
`endif

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      baud_done = 1'b1;
      @(negedge clk);
      baud_done = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int i, input logic odd);
    if (i == 0) return 1'b0;
    if (i <= DB) return d[i-1];
    if (P == 1 && i == DB + 1) return (^d) ^ odd;
    return 1'b1;
  endfunction

  task automatic start_req(input logic [7:0] d, input string tag);
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = d;
    @(posedge clk); #1;
    tx_start = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(tx_busy), 32'd1);
  endtask

  // Records one frame from the cycle after acceptance until tx_done, then checks every bit period.
  task automatic capture(input logic [7:0] d, input bit glitch, input string tag);
    int s, e;
    bit pre_ok;
    logic [3:0] seg;
    s = -1; e = -1;
    for (int n = 0; n < 200 && e < 0; n++) begin
      @(posedge clk); #1;
      txs[n] = tx; dns[n] = tx_done; bss[n] = tx_busy;
`ifdef UART_TX_PARITY_EN
      txo[n] = tx_odd;
`endif
      if (glitch && n == 12) begin tx_start = 1'b1; tx_data = 8'h3C; end
      if (glitch && n == 20) tx_start = 1'b0;
      if (s < 0 && tx == 1'b0) s = n;
      if (tx_done) e = n;
    end
    tx_start = 1'b0;
    if (s < 0 || e < 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_start_latency"}, 32'(s <= 3), 32'd1);
    pre_ok = 1'b1;
    for (int i = 0; i < s; i++) if (txs[i] !== 1'b1 || bss[i] !== 1'b1) pre_ok = 1'b0;
    check({tag, "_sync_idle_high"}, 32'(pre_ok), 32'd1);
    for (int i = 0; i < L; i++) begin
      seg = {txs[s+4*i], txs[s+4*i+1], txs[s+4*i+2], txs[s+4*i+3]};
      check($sformatf("%s_bit%0d", tag, i), 32'(seg), 32'({4{exp_bit(d, i, 1'b0)}}));
    end
`ifdef UART_TX_PARITY_EN
    seg = {txo[s+4*(DB+1)], txo[s+4*(DB+1)+1], txo[s+4*(DB+1)+2], txo[s+4*(DB+1)+3]};
    check({tag, "_odd_parity"}, 32'(seg), 32'({4{exp_bit(d, DB + 1, 1'b1)}}));
`endif
    check({tag, "_done_pos"}, 32'(e), 32'(s + 4*L));
    check({tag, "_busy_before_end"}, 32'(bss[e-1]), 32'd1);
    check({tag, "_busy_at_done"}, 32'(bss[e]), 32'd0);
    check({tag, "_tx_at_done"}, 32'(txs[e]), 32'd1);
  endtask

  task automatic idle_watch(input int cycles, input string tag);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) ok = 1'b0;
    end
    check({tag, "_quiet"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int s;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);
    reset = 1'b0;
    idle_watch(20, "post_reset");

    start_req(8'hA5, "a5");
    capture(8'hA5, 1'b0, "a5");

    start_req(8'hA5, "busy_req");
    capture(8'hA5, 1'b1, "busy_req");
    idle_watch(20, "after_ignored_3c");

    start_req(8'h96, "b2b_first");
    capture(8'h96, 1'b0, "b2b_first");
    start_req(8'h0F, "b2b_second");
    capture(8'h0F, 1'b0, "b2b_second");

    start_req(8'hA5, "abort");
    s = -1;
    for (int n = 0; n < 8 && s < 0; n++) begin
      @(posedge clk); #1;
      if (tx == 1'b0) s = n;
    end
    if (s < 0) begin
      check("abort_start_timeout", 32'd0, 32'd1);
    end else begin
      repeat (17) begin @(posedge clk); #1; end
      check("abort_in_bit3", 32'(tx), 32'd0);
      check("abort_busy_in_bit3", 32'(tx_busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_tx", 32'(tx), 32'd1);
      check("abort_busy", 32'(tx_busy), 32'd0);
      check("abort_done", 32'(tx_done), 32'd0);
      reset = 1'b0;
    end
    idle_watch(20, "after_abort");
    start_req(8'h55, "x55");
    capture(8'h55, 1'b0, "x55");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
